pipe_arb: RTL
=============

# pipe_arb

Round-robin scheduler that shares one arithmetic pipeline (operands `A`, `B`, `C` in; result `X` out; `stall` freezes every stage) among `NUM_REQ` requesters. It grants one operand set per cycle, tags each issue with its requester ID, and tracks tags alongside the pipeline. Results return on a single valid/ready response channel. The block drives the pipeline's `stall` input from response back-pressure, and sits between the requester ports and the pipeline instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `INP_WIDTH`, 2: width of each operand.
- `OUT_WIDTH`, 4: width of the pipeline result.
- `PIPE_DEPTH`, 2: cycles from operand capture to `X` valid when not stalled, ≥1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input NUM_REQ: per-requester request.
- `req_a`, `req_b`, `req_c` input NUM_REQ*INP_WIDTH each: packed operands; requester i uses slice [i*INP_WIDTH +: INP_WIDTH].
- `req_gnt` output NUM_REQ: one-hot grant; the operands are accepted at the posedge where `req_valid[i] & req_gnt[i]`.
- `pipe_a`, `pipe_b`, `pipe_c` output INP_WIDTH each: to the pipeline `A`/`B`/`C`.
- `pipe_stall` output 1: to the pipeline `stall`.
- `pipe_x` input OUT_WIDTH: from the pipeline `X`.
- `resp_valid` output 1, `resp_id` output $clog2(NUM_REQ), `resp_x` output OUT_WIDTH: response channel.
- `resp_ready` input 1: downstream accepts the response.

## Operation
- Tag pipe: `PIPE_DEPTH` entries of {valid, id}. It shifts on every posedge where `pipe_stall`=0. Entry 0 loads {grant_any, grant_id}. The last entry drives `resp_valid`/`resp_id`.
- `resp_x` = `pipe_x`, combinational passthrough.
- `pipe_stall` = `resp_valid & ~resp_ready`, combinational. The whole pipeline freezes, including bubbles. No bubble collapsing.
- Grant:
  - Combinational.
  - `req_gnt` is all-zero while `pipe_stall`=1.
  - Otherwise the first `req_valid` bit at or after `rr_ptr` (wrapping modulo `NUM_REQ`) is granted.
- `pipe_a/b/c` mux the granted requester's operands. They are 0 when there is no grant.
- `rr_ptr` becomes (granted index + 1) mod `NUM_REQ` on each accepted grant. It is unchanged otherwise.
- FSM, with state exposed only for debug/assertions:
  - IDLE: no valid tag in flight.
  - ACTIVE: at least one valid tag, not stalled.
  - STALLED: `pipe_stall`=1.
  - IDLE→ACTIVE on a grant.
  - ACTIVE→STALLED when `resp_valid & ~resp_ready`.
  - STALLED→ACTIVE when `resp_ready`=1.
  - ACTIVE→IDLE when the tag pipe empties with no new grant.
- A response is consumed at a posedge with `resp_valid & resp_ready`. Exactly one response is produced per accepted grant, in issue order.
- Requesters hold `req_valid` and operands until granted. The block does not buffer unaccepted requests.

## Timing
- Reset values: `req_gnt`=0, `pipe_a/b/c`=0, `pipe_stall`=0, `resp_valid`=0, `resp_id`=0, `rr_ptr`=0, all tags invalid, FSM IDLE.
- Latency: a grant accepted at edge t gives `resp_valid`=1 after edge t+PIPE_DEPTH-1. It is consumable at edge t+PIPE_DEPTH if `resp_ready`=1.
- Throughput: one issue per cycle when `resp_ready` is held high.
- Stall for N cycles adds exactly N cycles to every in-flight tag. `resp_id`/`resp_x` stay stable while stalled.
- A simultaneous `resp_ready` rise and new `req_valid` grants in that same cycle.
- A single requester repeatedly valid is granted every cycle.
- Async `rst` mid-operation:
  - All in-flight tags are dropped immediately, with no responses for them.
  - Outputs go to their reset values without waiting for `clk`.
  - The pipeline datapath content is ignored after reset because its tags are invalid.

## Configuration
- `PIPE_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins, and `rr_ptr` is removed.
  - Undefined (default): round-robin as in Operation.
  - All other behaviour is identical.

## Structure
- `pipe_arb_pkg`: `arb_state_t` enum {IDLE, ACTIVE, STALLED}; `tag_t` struct {valid, id}; function `id_w(n)` = $clog2 with a minimum of 1.
- One sub-module, `rr_grant`: combinational rotate-priority one-hot picker taking `req`, `ptr`, and `en`. Under `PIPE_ARB_FIXED_PRIO_EN` the `ptr` input is tied to 0.
- The tag pipe, `rr_ptr` and FSM live in the top module.

## Test plan
- Reset, then requester 1 presents A=1,B=1,C=1 with `resp_ready`=1 → `req_gnt`=0010. `resp_valid`=1 with `resp_id`=1 two cycles later. `resp_x` equals the pipeline result for (1,1,1).
- Requesters 0..3 all valid continuously → grants go 0,1,2,3,0,… one per cycle. `resp_id` follows the same sequence, offset by 2 cycles.
- With 2 tags in flight, drop `resp_ready` for 3 cycles → `pipe_stall`=1 for 3 cycles and `req_gnt`=0. `resp_id`/`resp_x` are held. Both responses arrive after release, in order.
- Requester 2 with A=3,B=1,C=2 issued, then `rst` pulsed mid-flight → `resp_valid`=0 immediately, and no response for that issue appears afterward.
- `rr_ptr`=3 with only requesters 0 and 2 valid → requester 0 is granted, then requester 2 (wrap-around).
- Build with `PIPE_ARB_FIXED_PRIO_EN`, requesters 0 and 3 valid continuously → requester 0 is granted every cycle and requester 3 never.

Source files
------------

// File: rtl/pipe_arb_pkg.sv
// Shared types and helpers for the pipe_arb pipeline scheduler.
// Optional build macro consumed by pipe_arb: PIPE_ARB_FIXED_PRIO_EN.
package pipe_arb_pkg;

  localparam int ID_MAX_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    STALLED
  } arb_state_t;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  function automatic int id_w(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/pipe_arb_rr_grant.sv
// Combinational rotate-priority one-hot picker: first request at or after ptr_i wins.
module rr_grant
  import pipe_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_any_o,
  output logic [IDW-1:0]     gnt_id_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_o     = '0;
    gnt_any_o = 1'b0;
    gnt_id_o  = '0;
    found     = 1'b0;
    idx       = 0;
    // k is the distance from the pointer; the first hit on that walk wins
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (en_i && !found && (i == idx) && req_i[i]) begin
          found     = 1'b1;
          gnt_o[i]  = 1'b1;
          gnt_any_o = 1'b1;
          gnt_id_o  = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/pipe_arb.sv
// Round-robin scheduler sharing one stallable arithmetic pipeline among NUM_REQ requesters.
// Define PIPE_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (no rr_ptr).
module pipe_arb
  import pipe_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int INP_WIDTH  = 2,
  parameter int OUT_WIDTH  = 4,
  parameter int PIPE_DEPTH = 2,
  localparam int IDW       = id_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*INP_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*INP_WIDTH-1:0]  req_b,
  input  logic [NUM_REQ*INP_WIDTH-1:0]  req_c,
  output logic [NUM_REQ-1:0]            req_gnt,
  output logic [INP_WIDTH-1:0]          pipe_a,
  output logic [INP_WIDTH-1:0]          pipe_b,
  output logic [INP_WIDTH-1:0]          pipe_c,
  output logic                          pipe_stall,
  input  logic [OUT_WIDTH-1:0]          pipe_x,
  output logic                          resp_valid,
  output logic [IDW-1:0]                resp_id,
  output logic [OUT_WIDTH-1:0]          resp_x,
  input  logic                          resp_ready
);

  localparam int LAST = PIPE_DEPTH - 1;

  logic             gnt_any;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   rr_ptr;
  tag_t             tags_q [PIPE_DEPTH];
  tag_t             tags_d [PIPE_DEPTH];
  arb_state_t       state_q, state_d;
  logic             busy_d;

  assign resp_valid = tags_q[LAST].valid;
  assign resp_id    = tags_q[LAST].id[IDW-1:0];
  assign resp_x     = pipe_x;
  assign pipe_stall = resp_valid & ~resp_ready;

  // Grants are suppressed while reset is held so outputs sit at reset values.
  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_grant (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr),
    .en_i      (~pipe_stall & ~rst),
    .gnt_o     (req_gnt),
    .gnt_any_o (gnt_any),
    .gnt_id_o  (gnt_id)
  );

`ifdef PIPE_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`endif

  always_comb begin
    pipe_a = '0;
    pipe_b = '0;
    pipe_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_gnt[i]) begin
        pipe_a = req_a[i*INP_WIDTH +: INP_WIDTH];
        pipe_b = req_b[i*INP_WIDTH +: INP_WIDTH];
        pipe_c = req_c[i*INP_WIDTH +: INP_WIDTH];
      end
    end
  end

  // Tags move in lockstep with the pipeline; bubbles freeze too.
  always_comb begin
    for (int i = 0; i < PIPE_DEPTH; i++) tags_d[i] = tags_q[i];
    if (!pipe_stall) begin
      for (int i = PIPE_DEPTH - 1; i > 0; i--) tags_d[i] = tags_q[i-1];
      tags_d[0].valid = gnt_any;
      tags_d[0].id    = ID_MAX_W'(gnt_id);
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) busy_d = busy_d | tags_d[i].valid;
    case (state_q)
      IDLE:    if (gnt_any) state_d = ACTIVE;
      ACTIVE: begin
        if (pipe_stall)   state_d = STALLED;
        else if (!busy_d) state_d = IDLE;
      end
      STALLED: if (resp_ready) state_d = ACTIVE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) tags_q[i] <= '0;
      state_q <= IDLE;
    end else begin
      for (int i = 0; i < PIPE_DEPTH; i++) tags_q[i] <= tags_d[i];
      state_q <= state_d;
    end
  end

endmodule
